posit_normalize_pipe: RTL and testbench
=======================================

// Module: posit_normalize_pipe
// PURPOSE
//  Two-stage pipelined posit encoder. Consumes the denormalized fields produced by the posit
//  denormalize stage or by an arithmetic core: sign/NaR/zero/scale/fraction/guard/round/sticky.
//  Emits a Posit<N,ES> word, rounded to nearest even and saturated, under valid/ready handshake.
//  Sits at the tail of every posit datapath, after the operator, before the result FIFO.
// PARAMETERS
//  POSIT_WIDTH  32  N, posit word width (>=5)
//  POSIT_ES      2  ES, exponent field width (>=0)
//  Derived: SW = get_scale_width(N,ES,NORMAL); FW = get_fraction_width(N,ES,NORMAL) = N-ES-3.
//  Derived: MAXS = (N-2)<<ES.
// PORTS
//  clk           input   1      rising-edge clock
//  rst_n         input   1      asynchronous active-low reset
//  s_valid       input   1      input fields valid
//  s_ready       output  1      block accepts input this cycle
//  denormalized  input   pd     pd.slave: sign, NaR, zero, scale[SW] (signed), fraction[FW]
//                               (hidden 1 excluded, MSB first), guard, round, sticky
//  m_valid       output  1      posit_o valid
//  m_ready       input   1      downstream accepts posit_o
//  posit_o       output  N      encoded posit word
// BEHAVIOUR
//  Reset (async, rst_n=0): v1=0, v2=0, m_valid=0, posit_o=0. All stage registers cleared.
//  Reset mid-flight discards in-flight words; no output is produced for them.
//  Handshake: transfer on valid&ready at either side.
//   - en2 = ~v2 | m_ready; en1 = ~v1 | en2; s_ready = en1 (combinational, no s_valid dependence).
//   - m_valid = v2. posit_o is held stable while m_valid & ~m_ready.
//   - Latency 2 cycles with m_ready=1; throughput 1/cycle; full backpressure without loss.
//  Stage 1 (en1): special detect, clamp, assemble.
//   - NaR has priority over zero. NaR -> code 1<<(N-1); zero -> code 0; no rounding applied.
//   - Clamp: scale >= MAXS  -> maxpos magnitude (N-1 ones), frac/round ignored.
//            scale <  -MAXS -> minpos magnitude (1).
//   - Otherwise k = scale>>>ES (arithmetic shift), e = scale[ES-1:0].
//     k>=0: regime = (k+1) ones, then one 0. k<0: regime = -k zeros, then one 1.
//   - Build ext = {regime, e, fraction, guard, round, sticky} left-aligned on a 2N-bit register.
//   - Keep top N-1 bits as mag. Set L = LSB of mag, R = next bit, S = OR of all lower bits.
//   - Register mag, L, R, S, sign, and the special/saturation flags.
//  Stage 2 (en2): round, finalize.
//   - mag' = mag + (R & (L|S)). Round to nearest, ties to even.
//   - A nonzero, non-NaR result never rounds to 0 and never exceeds maxpos.
//     mag'==0 -> 1; overflow past N-1 ones -> N-1 ones.
//   - word = {0, mag'}; if sign, word = -word (N-bit two's complement). Register into posit_o.
//  Widths: all regime/shift arithmetic uses $clog2(2N)+1 bit signed internal values.
//   - scale is sign-extended from SW; no truncation is permitted.
//  ES=0: exponent field absent; e is ignored. Build stays legal; no zero-width slices.
//  Simultaneous accept and emit in one cycle is legal and required when m_ready=1.
// TESTING  (N=8, ES=0 unless stated; SW=4, FW=5)
//  1. zero=1 -> 0x00; NaR=1, zero=1 -> 0x80. Both out 2 cycles after accept.
//  2. scale=0, frac=0 -> 0x40. scale=1 -> 0x60. scale=-1 -> 0x20. sign=1, scale=0 -> 0xC0.
//  3. scale=0, frac=5'b10000 -> 0x50. Rounding at scale=5, frac=5'b10000:
//     g=r=s=0 -> 0x7E (tie to even); with sticky=1 -> 0x7F.
//  4. Saturation: scale=6 -> 0x7F; scale=7 (clamped) -> 0x7F; scale=-7 -> 0x01.
//     sign=1, scale=-7 -> 0xFF.
//  5. Back-to-back stream of 16 random words, m_ready toggled 50%:
//     no drop or duplicate, order preserved, posit_o stable during stall.
//     Check against posit_denormalize round-trip (N=32, ES=2).
//  6. rst_n pulsed low with v1=v2=1 -> m_valid=0 at once. First post-reset accept appears
//     after 2 cycles.

Source files
------------

// File: rtl/posit_normalize_pipe.sv
// Two-stage posit encoder: turns sign/special/scale/fraction/GRS fields into a Posit<N,ES> word,
// rounded to nearest even and saturated to [minpos, maxpos], behind a valid/ready pipeline.
module posit_normalize_pipe #(
  parameter  int POSIT_WIDTH = 32,
  parameter  int POSIT_ES    = 2,
  localparam int SW          = $clog2(POSIT_WIDTH - 1) + POSIT_ES + 1,
  localparam int FW          = POSIT_WIDTH - POSIT_ES - 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   sign_i,
  input  logic                   nar_i,
  input  logic                   zero_i,
  input  logic [SW-1:0]          scale_i,
  input  logic [FW-1:0]          fraction_i,
  input  logic                   guard_i,
  input  logic                   round_i,
  input  logic                   sticky_i,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [POSIT_WIDTH-1:0] posit_o
);
  localparam int N  = POSIT_WIDTH;
  localparam int ES = POSIT_ES;
  localparam int IW = $clog2(2 * N) + 1;
  // Comparison width holds both the raw scale and the regime arithmetic without truncation.
  localparam int CW = ((SW > IW) ? SW : IW) + 1;
  localparam logic signed [CW-1:0] MAXS = CW'((N - 2) << ES);
  localparam logic signed [CW-1:0] MINS = -MAXS;

  logic en1_s, en2_s;
  logic v1_q, v2_q;
  logic sign_q, nar_q, zero_q, smax_q, smin_q;
  logic [N-2:0] mag_q;
  logic l_q, r_q, st_q;
  logic [N-1:0] posit_q;

  logic signed [CW-1:0] scale_x_s;
  logic signed [IW-1:0] k_s;
  logic                 k_neg_s;
  logic [IW-1:0]        shamt_s;
  logic [N-1:0]         tail_s;
  logic [2*N-1:0]       body_s, ext_s;
  logic [N-2:0]         mag_d;
  logic                 l_d, r_d, st_d, smax_d, smin_d;

  assign en2_s   = ~v2_q | m_ready;
  assign en1_s   = ~v1_q | en2_s;
  assign s_ready = en1_s;
  assign m_valid = v2_q;
  assign posit_o = posit_q;

  assign scale_x_s = {{(CW - SW){scale_i[SW-1]}}, scale_i};
  assign k_s       = IW'(scale_x_s >>> ES);
  assign k_neg_s   = k_s[IW-1];

  generate
    if (ES > 0) begin : g_exp
      assign tail_s = {scale_i[ES-1:0], fraction_i, guard_i, round_i, sticky_i};
    end else begin : g_noexp
      assign tail_s = {fraction_i, guard_i, round_i, sticky_i};
    end
  endgenerate

  // Stage 1: regime run + terminator, then the tail, left-aligned and split into mag/L/R/S.
  always_comb begin
    shamt_s = {IW{1'b0}};
    body_s  = {k_neg_s, tail_s, {(N - 1){1'b0}}};
    ext_s   = {(2 * N){1'b0}};
    if (k_neg_s) begin
      shamt_s = -k_s;
      ext_s   = body_s >> shamt_s;
    end else begin
      shamt_s = k_s + IW'(1);
      ext_s   = ~((~body_s) >> shamt_s);
    end
    mag_d  = ext_s[2*N-1 -: N-1];
    l_d    = ext_s[N+1];
    r_d    = ext_s[N];
    st_d   = |ext_s[N-1:0];
    smax_d = (scale_x_s >= MAXS);
    smin_d = (scale_x_s < MINS);
  end

  // Stage 1 registers: loaded whenever stage 1 can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      sign_q <= 1'b0;
      nar_q  <= 1'b0;
      zero_q <= 1'b0;
      smax_q <= 1'b0;
      smin_q <= 1'b0;
      mag_q  <= {(N - 1){1'b0}};
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      st_q   <= 1'b0;
    end else if (en1_s) begin
      v1_q <= s_valid;
      if (s_valid) begin
        sign_q <= sign_i;
        nar_q  <= nar_i;
        zero_q <= zero_i;
        smax_q <= smax_d;
        smin_q <= smin_d;
        mag_q  <= mag_d;
        l_q    <= l_d;
        r_q    <= r_d;
        st_q   <= st_d;
      end
    end
  end

  logic         inc_s;
  logic [N-1:0] sum_s;
  logic [N-2:0] mag_rnd_s, mag_fin_s;
  logic [N-1:0] word_s;

  assign inc_s = r_q & (l_q | st_q);
  assign sum_s = {1'b0, mag_q} + {{(N - 1){1'b0}}, inc_s};

  // Stage 2: round-to-nearest-even, keep inside [minpos, maxpos], apply specials and sign.
  always_comb begin
    mag_rnd_s = sum_s[N-2:0];
    mag_fin_s = {(N - 1){1'b0}};
    word_s    = {N{1'b0}};
    if (sum_s[N-1]) begin
      mag_rnd_s = {(N - 1){1'b1}};
    end else if (sum_s == {N{1'b0}}) begin
      mag_rnd_s = {{(N - 2){1'b0}}, 1'b1};
    end else begin
      mag_rnd_s = sum_s[N-2:0];
    end
    if (smax_q) begin
      mag_fin_s = {(N - 1){1'b1}};
    end else if (smin_q) begin
      mag_fin_s = {{(N - 2){1'b0}}, 1'b1};
    end else begin
      mag_fin_s = mag_rnd_s;
    end
    if (nar_q) begin
      word_s = {1'b1, {(N - 1){1'b0}}};
    end else if (zero_q) begin
      word_s = {N{1'b0}};
    end else if (sign_q) begin
      word_s = ~{1'b0, mag_fin_s} + {{(N - 1){1'b0}}, 1'b1};
    end else begin
      word_s = {1'b0, mag_fin_s};
    end
  end

  // Stage 2 registers: output word holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      posit_q <= {N{1'b0}};
    end else if (en2_s) begin
      v2_q <= v1_q;
      if (v1_q) begin
        posit_q <= word_s;
      end
    end
  end
endmodule

// File: tb/tb_posit_normalize_pipe.sv
// Directed bench for posit_normalize_pipe at N=8, ES=0 (SW=4, FW=5).
module tb_posit_normalize_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic       sign_i, nar_i, zero_i, guard_i, round_i, sticky_i;
  logic [3:0] scale_i;
  logic [4:0] fraction_i;
  logic [7:0] posit_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       sg, nr, zr;
    logic [3:0] sc;
    logic [4:0] fr;
    logic       g, r, st;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[21];

  posit_normalize_pipe #(.POSIT_WIDTH(8), .POSIT_ES(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .sign_i(sign_i), .nar_i(nar_i), .zero_i(zero_i), .scale_i(scale_i),
    .fraction_i(fraction_i), .guard_i(guard_i), .round_i(round_i), .sticky_i(sticky_i),
    .m_valid(m_valid), .m_ready(m_ready), .posit_o(posit_o)
  );

  always #5 clk = ~clk;

  task automatic init_table();
    //            sg    nr    zr    sc     fr        g     r     st    exp
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h80};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'h1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h60};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'hF, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h20};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hC0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 5'b10000, 1'b0, 1'b0, 1'b0, 8'h50};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h5, 5'b10000, 1'b0, 1'b0, 1'b0, 8'h7E};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h5, 5'b10000, 1'b0, 1'b0, 1'b1, 8'h7F};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h4, 5'b11000, 1'b0, 1'b0, 1'b0, 8'h7E};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 5'b11111, 1'b1, 1'b0, 1'b0, 8'h60};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h6, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h7F};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h7, 5'b11111, 1'b1, 1'b1, 1'b1, 8'h7F};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'h9, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 4'h9, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hFF};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 4'h1, 5'b01000, 1'b0, 1'b0, 1'b0, 8'h9C};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 4'hA, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 4'h8, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 4'h2, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h70};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 4'hD, 5'b10000, 1'b0, 1'b0, 1'b0, 8'h0C};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 4'h3, 5'b11111, 1'b1, 1'b1, 1'b1, 8'h80};
  endtask

  task automatic set_fields(input vec_t v);
    sign_i = v.sg; nar_i = v.nr; zero_i = v.zr; scale_i = v.sc;
    fraction_i = v.fr; guard_i = v.g; round_i = v.r; sticky_i = v.st;
  endtask

  // One word through an empty pipe with m_ready=1; lat_ok means invisible after the
  // accept edge and valid after the following edge.
  task automatic run_one(input vec_t v, output logic [7:0] got, output bit lat_ok);
    bit acc;
    @(negedge clk);
    set_fields(v); s_valid = 1'b1; m_ready = 1'b1;
    #1 acc = s_ready;
    @(negedge clk);
    s_valid = 1'b0;
    lat_ok = acc && (m_valid === 1'b0);
    @(negedge clk);
    lat_ok = lat_ok && (m_valid === 1'b1);
    got = posit_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    set_fields(tbl[2]);
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || posit_o !== 8'h00 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: m_valid=%b posit_o=%h s_ready=%b, want 0/00/1", m_valid, posit_o, s_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_group(input string name, input int ids[], input int cnt);
    logic [7:0] got;
    bit lat_ok;
    for (int i = 0; i < cnt; i++) begin
      run_one(tbl[ids[i]], got, lat_ok);
      n_checks++;
      if (got !== tbl[ids[i]].exp) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h want %h", name, ids[i], got, tbl[ids[i]].exp);
      end
      n_checks++;
      if (!lat_ok) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: output not exactly 2 cycles after accept", name, ids[i]);
      end
    end
  endtask

  task automatic test_specials();
    int ids[] = '{0, 1, 20};
    test_group("specials", ids, 3);
  endtask

  task automatic test_basic();
    int ids[] = '{2, 3, 4, 5, 18, 6, 15};
    test_group("basic", ids, 7);
  endtask

  task automatic test_rounding();
    int ids[] = '{7, 8, 9, 10, 19};
    test_group("rounding", ids, 5);
  endtask

  task automatic test_saturation();
    int ids[] = '{11, 12, 13, 14, 16, 17};
    test_group("saturation", ids, 6);
  endtask

  task automatic test_back_to_back();
    int in_idx = 0, out_idx = 0, cyc = 0;
    bit held = 1'b0, acc, emit;
    logic [7:0] held_val = 8'h00;
    logic [31:0] pat = 32'hB4E1_6C39;
    while (out_idx < 16 && cyc < 400) begin
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (m_valid !== 1'b1 || posit_o !== held_val) begin
          n_fail++;
          $display("FAIL stall_hold: m_valid=%b posit_o=%h, want 1/%h", m_valid, posit_o, held_val);
        end
      end
      m_ready = pat[cyc % 32];
      if (in_idx < 16) begin
        set_fields(tbl[in_idx]); s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      acc  = s_valid & s_ready;
      emit = m_valid & m_ready;
      if (emit) begin
        n_checks++;
        if (posit_o !== tbl[out_idx].exp) begin
          n_fail++;
          $display("FAIL stream[%0d]: got %h want %h", out_idx, posit_o, tbl[out_idx].exp);
        end
        out_idx++;
      end
      held = m_valid & ~m_ready;
      held_val = posit_o;
      @(posedge clk);
      if (acc) in_idx++;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    n_checks++;
    if (out_idx != 16) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words want 16 within budget", out_idx);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_extra: m_valid=%b after stream drained, want 0", m_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] got;
    bit lat_ok;
    @(negedge clk);
    m_ready = 1'b0; set_fields(tbl[3]); s_valid = 1'b1;
    @(negedge clk);
    set_fields(tbl[4]);
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: m_valid=%b s_ready=%b, want 1/0", m_valid, s_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || posit_o !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: m_valid=%b posit_o=%h, want 0/00", m_valid, posit_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_one(tbl[7], got, lat_ok);
    n_checks++;
    if (got !== 8'h7E || !lat_ok) begin
      n_fail++;
      $display("FAIL post_reset: got %h lat_ok=%b, want 7E/1", got, lat_ok);
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_specials();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
